vga_sync_decoder: RTL and testbench

Sync-side counterpart of the VGA timing generator: takes the `hsync`/`vsync` pair as driven to the connector and recovers `hcount`/`vcount` and blanking. It also checks every sync edge against the 800x600@60 timing and reports lock and error status. It sits in the same 40 MHz domain as the generator and serves as the in-design timing monitor and as the checker used by the top-level bench.

---
 rtl/vga_sync_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel/line counters and blanking from an hsync/vsync pair that is
// synchronous to the pixel clock. It checks every sync edge against the
// nominal timing, realigns on every edge, and reports lock and error status.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hsync        horizontal sync, active high
//   vsync        vertical sync, active high
//   hcount       recovered pixel column (source column delayed by one cycle)
//   vcount       recovered line
//   hblnk        high while hcount >= H_ACT
//   vblnk        high while vcount >= V_ACT
//   frame_start  one-cycle pulse when outputs show 0/0 outside SEARCH
//   locked       high in LOCKED
//   sync_err     one-cycle pulse on any edge arriving at the wrong position
//   err_cnt      saturating count of sync_err pulses
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOT       = 1056,
  parameter int H_ACT       = 800,
  parameter int H_SYNC_S    = 840,
  parameter int H_SYNC_E    = 968,
  parameter int V_TOT       = 628,
  parameter int V_ACT       = 600,
  parameter int V_SYNC_S    = 601,
  parameter int V_SYNC_E    = 605,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 2112
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);
  localparam logic [10:0] H_ACT_C = 11'(H_ACT);
  localparam logic [10:0] V_ACT_C = 11'(V_ACT);
  localparam logic [10:0] HSS_C   = 11'(H_SYNC_S);
  localparam logic [10:0] HSE_C   = 11'(H_SYNC_E);
  localparam logic [10:0] VSS_C   = 11'(V_SYNC_S);
  localparam logic [10:0] VSE_C   = 11'(V_SYNC_E);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_FRAMES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  // ---------------- edge detection (bit 0 = hsync, bit 1 = vsync) --------
  logic [1:0] sync_in;
  logic [1:0] sync_rise;
  logic [1:0] sync_fall;

  assign sync_in = {vsync, hsync};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      logic prev_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_reg <= 1'b0;
        else        prev_reg <= sync_in[gi];
      end
      assign sync_rise[gi] = sync_in[gi] & ~prev_reg;
      assign sync_fall[gi] = ~sync_in[gi] & prev_reg;
    end
  endgenerate

  logic h_rise, h_fall, v_rise, v_fall;
  assign h_rise = sync_rise[0];
  assign h_fall = sync_fall[0];
  assign v_rise = sync_rise[1];
  assign v_fall = sync_fall[1];

  // ---------------- state ------------------------------------------------
  logic [1:0]    state_reg, state_next;
  logic [GW-1:0] good_reg, good_next, good_inc;
  logic          dirty_reg, dirty_next;
  logic [WW-1:0] wdog_reg, wdog_next;
  logic [10:0]   h_next, v_next;
  logic          err_next;
  logic [7:0]    err_cnt_next;

  // Free-running prediction of where the counters go if no edge intervenes.
  logic [10:0] nh, nv;
  assign nh = (hcount == H_LAST) ? 11'd0 : hcount + 11'd1;
  assign nv = (nh != 11'd0) ? vcount : ((vcount == V_LAST) ? 11'd0 : vcount + 11'd1);

  logic mismatch;
  assign mismatch = (h_rise && (nh != HSS_C)) ||
                    (h_fall && (nh != HSE_C)) ||
                    (v_rise && ((nh != 11'd0) || (nv != VSS_C))) ||
                    (v_fall && ((nh != 11'd0) || (nv != VSE_C)));

  // Watchdog expires when it would count past TIMEOUT-1 without an hsync rise.
  logic timeout;
  assign timeout = ~h_rise && (wdog_reg == WD_LAST);

  assign good_inc = dirty_reg ? good_reg : good_reg + GW'(1);

  always_comb begin
    state_next   = state_reg;
    good_next    = good_reg;
    dirty_next   = dirty_reg;
    h_next       = nh;
    v_next       = nv;
    err_next     = 1'b0;
    err_cnt_next = err_cnt;
    wdog_next    = (h_rise || timeout) ? '0 : wdog_reg + WW'(1);

    if (timeout) begin
      // Loss of sync: silent drop back to SEARCH.
      state_next = ST_SEARCH;
      h_next     = 11'd0;
      v_next     = 11'd0;
    end else begin
      case (state_reg)
        ST_SEARCH: begin
          h_next = 11'd0;
          v_next = 11'd0;
          if (v_rise) begin
            v_next     = VSS_C;
            good_next  = '0;
            dirty_next = 1'b0;
            state_next = ST_ALIGN;
          end
        end
        ST_ALIGN, ST_LOCKED: begin
          // Every edge snaps the counters to where that edge belongs; the
          // vsync loads come last so they win over a coincident hsync edge.
          if (h_rise) h_next = HSS_C;
          if (h_fall) h_next = HSE_C;
          if (v_rise) begin
            h_next = 11'd0;
            v_next = VSS_C;
          end
          if (v_fall) begin
            h_next = 11'd0;
            v_next = VSE_C;
          end

          if (mismatch) begin
            err_next     = 1'b1;
            err_cnt_next = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            dirty_next   = 1'b1;
            good_next    = '0;
            state_next   = ST_ALIGN;
          end else if (v_rise && (state_reg == ST_ALIGN)) begin
            good_next  = good_inc;
            dirty_next = 1'b0;
            if (good_inc == LOCK_C) state_next = ST_LOCKED;
          end
        end
        default: begin
          state_next = ST_SEARCH;
          h_next     = 11'd0;
          v_next     = 11'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_SEARCH;
      good_reg    <= '0;
      dirty_reg   <= 1'b0;
      wdog_reg    <= '0;
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      state_reg   <= state_next;
      good_reg    <= good_next;
      dirty_reg   <= dirty_next;
      wdog_reg    <= wdog_next;
      hcount      <= h_next;
      vcount      <= v_next;
      // Status outputs derive from next values so they line up with counters.
      hblnk       <= (h_next >= H_ACT_C);
      vblnk       <= (v_next >= V_ACT_C);
      frame_start <= (h_next == 11'd0) && (v_next == 11'd0) && (state_next != ST_SEARCH);
      locked      <= (state_next == ST_LOCKED);
      sync_err    <= err_next;
      err_cnt     <= err_cnt_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Scaled-down timing keeps the run short. A source generator drives the sync
// pair (with skipped/stalled pixels, glitches, dropouts and resets), a
// reference model predicts every output cycle into a queue, and a monitor
// pops and compares after each clock edge. Directed checks cover lock time,
// frame_start period, error positions, timeout and err_cnt saturation.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT  = 64;
  localparam int HA  = 48;
  localparam int HSS = 50;
  localparam int HSE = 58;
  localparam int VT  = 20;
  localparam int VA  = 12;
  localparam int VSS = 13;
  localparam int VSE = 16;
  localparam int LF  = 2;
  localparam int TO  = 128;
  localparam int F   = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic [10:0] hcount, vcount;
  logic        hblnk, vblnk, frame_start, locked, sync_err;
  logic [7:0]  err_cnt;

  vga_sync_decoder #(
    .H_TOT(HT), .H_ACT(HA), .H_SYNC_S(HSS), .H_SYNC_E(HSE),
    .V_TOT(VT), .V_ACT(VA), .V_SYNC_S(VSS), .V_SYNC_E(VSE),
    .LOCK_FRAMES(LF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .hblnk(hblnk), .vblnk(vblnk),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int h;
    int v;
    bit hb;
    bit vb;
    bit fs;
    bit lk;
    bit se;
    int ec;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_lvl = 1'b0;

  // reference model state
  int m_phs = 0, m_pvs = 0, m_h = 0, m_v = 0, m_mode = 0;
  int m_good = 0, m_dirty = 0, m_since = 0, m_errs = 0;

  int t_align = -1;
  int t_lock = -1;
  int fs_times[$];
  int err_pulses = 0;

  // source generator state
  int src_h = 30, src_v = 8;
  int skip_at = -1, stall_at = -1, glitch_at = -1;

  // ---------------- reference model ---------------------------------------
  // Mode: 0 searching, 1 aligning, 2 locked. Timeout measured as cycles
  // since the last hsync rise.
  task automatic model_step(input bit hs, input bit vs, input bit rst, output exp_t e);
    bit hr, hf, vr, vf, err;
    int ph, pv;
    err = 1'b0;
    if (!rst) begin
      m_phs = 0; m_pvs = 0; m_h = 0; m_v = 0; m_mode = 0;
      m_good = 0; m_dirty = 0; m_since = 0; m_errs = 0;
    end else begin
      hr = hs && (m_phs == 0);
      hf = !hs && (m_phs == 1);
      vr = vs && (m_pvs == 0);
      vf = !vs && (m_pvs == 1);
      m_phs = hs; m_pvs = vs;
      if (hr) m_since = 0; else m_since++;
      if (m_since == TO) begin
        m_mode = 0; m_h = 0; m_v = 0; m_since = 0;
      end else if (m_mode == 0) begin
        m_h = 0; m_v = 0;
        if (vr) begin
          m_v = VSS; m_good = 0; m_dirty = 0; m_mode = 1;
          if (t_align < 0) t_align = cyc;
        end
      end else begin
        ph = (m_h + 1) % HT;
        pv = (ph == 0) ? (m_v + 1) % VT : m_v;
        err = (hr && ph != HSS) || (hf && ph != HSE) ||
              (vr && (ph != 0 || pv != VSS)) || (vf && (ph != 0 || pv != VSE));
        m_h = ph; m_v = pv;
        if (hr) m_h = HSS;
        if (hf) m_h = HSE;
        if (vr) begin m_h = 0; m_v = VSS; end
        if (vf) begin m_h = 0; m_v = VSE; end
        if (err) begin
          if (m_errs < 255) m_errs++;
          m_dirty = 1; m_good = 0; m_mode = 1;
        end else if (vr && m_mode == 1) begin
          if (m_dirty == 0) m_good++;
          m_dirty = 0;
          if (m_good == LF) m_mode = 2;
        end
      end
    end
    e.idx = cyc;
    e.h   = m_h;
    e.v   = m_v;
    e.hb  = (m_h >= HA);
    e.vb  = (m_v >= VA);
    e.fs  = (m_h == 0) && (m_v == 0) && (m_mode != 0);
    e.lk  = (m_mode == 2);
    e.se  = err;
    e.ec  = m_errs;
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick(input bit hs, input bit vs);
    exp_t e;
    @(negedge clk);
    hsync = hs;
    vsync = vs;
    rst_n = rst_lvl;
    cyc++;
    model_step(hs, vs, rst_lvl, e);
    exp_q.push_back(e);
  endtask

  task automatic src_tick();
    bit hs, vs;
    hs = (src_h >= HSS) && (src_h < HSE);
    vs = (src_v >= VSS) && (src_v < VSE);
    if (src_h == glitch_at) begin
      hs = ~hs;
      glitch_at = -1;
    end
    tick(hs, vs);
    if (src_h == stall_at) begin
      stall_at = -1;
    end else begin
      src_h++;
      if (src_h == skip_at) begin
        src_h++;
        skip_at = -1;
      end
      if (src_h >= HT) begin
        src_h = 0;
        src_v = (src_v + 1) % VT;
      end
    end
  endtask

  task automatic src_run(input int n);
    repeat (n) src_tick();
  endtask

  task automatic src_until(input int h, input int v);
    int guard;
    guard = 0;
    while (!(src_h == h && src_v == v) && guard < 3 * F) begin
      src_tick();
      guard++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------------------------
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (hcount !== 11'(e.h) || vcount !== 11'(e.v) || hblnk !== e.hb ||
            vblnk !== e.vb || frame_start !== e.fs || locked !== e.lk ||
            sync_err !== e.se || err_cnt !== 8'(e.ec)) begin
          failures++;
          $display("FAIL outputs cycle %0d: got h=%0d v=%0d hb=%b vb=%b fs=%b lk=%b se=%b ec=%0d, required h=%0d v=%0d hb=%b vb=%b fs=%b lk=%b se=%b ec=%0d",
                   e.idx, hcount, vcount, hblnk, vblnk, frame_start, locked, sync_err, err_cnt,
                   e.h, e.v, e.hb, e.vb, e.fs, e.lk, e.se, e.ec);
        end
        if (locked === 1'b1 && t_lock < 0) t_lock = e.idx;
        if (frame_start === 1'b1) fs_times.push_back(e.idx);
        if (sync_err === 1'b1) err_pulses++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL run_time_limit: got no finish, required finish");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence -----------------------------------------
  initial begin
    int p0, r;

    // Power-up reset while the source already runs mid-frame.
    rst_lvl = 1'b0;
    src_run(3);
    settle();
    chk("reset_hcount", int'(hcount), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    rst_lvl = 1'b1;

    // Nominal acquisition.
    src_run(4 * F);
    settle();
    chk("lock_latency", t_lock - t_align, 2 * F);
    chk("frame_start_count_ge2", int'(fs_times.size() >= 2), 1);
    if (fs_times.size() >= 2) chk("frame_start_period", fs_times[1] - fs_times[0], F);
    chk("locked_nominal", int'(locked), 1);

    // Early hsync: source skips the pixel just before the sync start.
    src_until(0, 5);
    skip_at = HSS - 1;
    src_until(HSS, 5);
    src_tick();
    settle();
    chk("early_sync_err", int'(sync_err), 1);
    chk("early_err_cnt", int'(err_cnt), 1);
    chk("early_locked", int'(locked), 0);
    chk("early_hcount", int'(hcount), HSS);
    src_run(3 * F + HT);
    settle();
    chk("early_relock", int'(locked), 1);

    // Short hsync pulse: falls one pixel early.
    src_until(0, 5);
    skip_at = HSE - 1;
    src_until(HSE, 5);
    src_tick();
    settle();
    chk("short_sync_err", int'(sync_err), 1);
    chk("short_hcount", int'(hcount), HSE);
    src_run(3 * F + HT);
    settle();
    chk("short_relock", int'(locked), 1);

    // Loss of sync.
    src_until(0, 5);
    settle();
    p0 = err_pulses;
    repeat (TO + 20) tick(1'b0, 1'b0);
    settle();
    chk("loss_locked", int'(locked), 0);
    chk("loss_hcount", int'(hcount), 0);
    chk("loss_vcount", int'(vcount), 0);
    chk("loss_no_err", err_pulses - p0, 0);
    src_run(3 * F + HT);
    settle();
    chk("loss_relock", int'(locked), 1);

    // Reset mid-frame.
    src_until(30, 10);
    rst_lvl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_tick();
      settle();
      chk("midreset_hcount", int'(hcount), 0);
      chk("midreset_locked", int'(locked), 0);
    end
    rst_lvl = 1'b1;
    src_until(0, VSS);
    src_tick();
    settle();
    chk("realign_hcount", int'(hcount), 0);
    chk("realign_vcount", int'(vcount), VSS);

    // Randomised disturbances, one decision per line.
    for (int ln = 0; ln < 4 * VT; ln++) begin
      int guard;
      r = int'($urandom_range(0, 11));
      case (r)
        0: skip_at   = int'($urandom_range(1, HT - 2));
        1: stall_at  = int'($urandom_range(1, HT - 2));
        2: glitch_at = int'($urandom_range(1, HT - 2));
        3: begin
          rst_lvl = 1'b0;
          src_run(2);
          rst_lvl = 1'b1;
        end
        default: ;
      endcase
      guard = 0;
      do begin
        src_tick();
        guard++;
      end while (src_h != 0 && guard < 2 * HT);
      skip_at = -1;
      stall_at = -1;
      glitch_at = -1;
    end

    // Error counter saturation: 300 misplaced rises, each with a correct fall.
    src_run(2 * F);
    src_until(0, 5);
    settle();
    p0 = err_pulses;
    repeat (300) begin
      repeat (3) tick(1'b0, 1'b0);
      repeat (HSE - HSS) tick(1'b1, 1'b0);
    end
    tick(1'b0, 1'b0);
    settle();
    chk("sat_pulses", err_pulses - p0, 300);
    chk("sat_err_cnt", int'(err_cnt), 255);

    settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
